fwd_hazard_unit_n: RTL and testbench
====================================

Name: fwd_hazard_unit_n

Overview:
- Parametrised forwarding and hazard unit for the N-lane superscalar pipeline; supersedes the fixed dual-lane forwarding block.
- Generates per-operand forward selects for the EXE stage and for the ID stage, where branches compare their operands.
- Detects load-use and branch-operand hazards and issues stall/bubble controls.
- Tracks the iterative multiply/divide unit (fixed latency) with a busy FSM, stalling HI/LO consumers, and keeps a saturating stall-cycle counter.

Parameters:
- NUM_LANES, 2, issue width; must be >= 2.
- REG_AW, 5, register address width.
- LANE_W, 1, lane index width, equal to max(1, clog2(NUM_LANES)).
- MD_LATENCY, 4, cycles a mult/div occupies the MD unit; must be >= 1.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs_id, rt_id  in  NUM_LANES*REG_AW each  ID source registers; lane k occupies bits [k*REG_AW +: REG_AW].
- branch_id  in  NUM_LANES  lane holds a branch that compares in ID.
- uses_hilo_id  in  NUM_LANES  lane reads HI/LO or is itself a mult/div.
- rs_exe, rt_exe  in  NUM_LANES*REG_AW each  EXE source registers.
- regwrite_exe, memread_exe  in  NUM_LANES each  per-lane EXE write and load flags.
- writereg_exe  in  NUM_LANES*REG_AW  EXE destination registers.
- md_start_exe  in  1  a valid mult/div is in EXE this cycle (one-cycle pulse).
- regwrite_mem, memread_mem  in  NUM_LANES each  per-lane MEM write and load flags.
- writereg_mem  in  NUM_LANES*REG_AW  MEM destination registers.
- regwrite_wb  in  NUM_LANES  per-lane WB write flag.
- writereg_wb  in  NUM_LANES*REG_AW  WB destination registers.
- fwd_a_exe, fwd_b_exe  out  NUM_LANES*(2+LANE_W) each  EXE forward selects.
- fwd_a_id, fwd_b_id  out  NUM_LANES*(2+LANE_W) each  ID forward selects.
- stall_pc, stall_id, bubble_exe  out  1 each  hold PC, hold IF/ID, insert NOP into ID/EXE.
- md_busy  out  1  MD FSM is in BUSY.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Forward select encoding: bits[1:0] are 00 = register file, 10 = MEM, 01 = WB. Bits[2+:LANE_W] carry the producing lane, and are 0 when bits[1:0] = 00. With NUM_LANES = 2 this gives 3'b010/3'b110 for MEM lane 0/1 and 3'b001/3'b101 for WB lane 0/1.
- EXE select per operand:
  - Source 0 always gives 00.
  - A MEM match (regwrite_mem & writereg equal) beats any WB match.
  - Within a stage, the highest matching lane index wins, because it is youngest in program order. This deliberately inverts the old lane-0 priority.
- ID select per operand: same rules, computed from rs_id/rt_id against MEM/WB. Evaluated for every lane regardless of branch_id.
- Combinational outputs (fwd_*, stall_pc, stall_id, bubble_exe) carry no reset value; they are functions of their inputs and md_busy.
- Hazard terms, all evaluated combinationally and ignoring source 0:
  - H_LOAD: any ID lane rs/rt equals writereg_exe of a lane with regwrite_exe & memread_exe.
  - H_BR_EXE: a branch_id lane source equals writereg_exe of any lane with regwrite_exe, whether load or ALU.
  - H_BR_MEM: a branch_id lane source equals writereg_mem of a lane with regwrite_mem & memread_mem.
  - H_MD: any uses_hilo_id lane while md_busy or md_start_exe.
- stall = OR of all hazard terms. stall_pc = stall_id = bubble_exe = stall, in the same cycle.
- A load feeding a branch therefore stalls 2 cycles: first via H_BR_EXE, then via H_BR_MEM after the bubble.
- MD FSM states are IDLE and BUSY, with a down-counter md_cnt of width clog2(MD_LATENCY+1):
  - IDLE with md_start_exe: go to BUSY and load md_cnt = MD_LATENCY-1.
  - BUSY with md_cnt != 0: decrement md_cnt.
  - BUSY with md_cnt == 0: go to IDLE.
  - md_start_exe while BUSY is ignored, because H_MD prevents a second MD op from issuing.
  - md_busy = (state == BUSY), registered; total occupancy is MD_LATENCY cycles after the start cycle.
- stall_cnt: increments by 1 on every clock edge where stall = 1 and saturates at all-ones.
- Reset (rst_n = 0, any time including mid-BUSY) forces immediately: state IDLE, md_cnt 0, md_busy 0, stall_cnt 0.
- Lanes in the same ID bundle sourcing each other are resolved by the issue logic and are out of scope here.

Test Plan:
- Lane 0 EXE rs = 5; MEM lane 0 and lane 1 both write r5; WB lane 0 writes r5 -> fwd_a_exe lane 0 = 3'b110; no stall.
- Lane 1 rt_exe = 0, with every stage writing r0 -> fwd_b_exe lane 1 = 3'b000.
- Lane 1 ID rs = 8; EXE lane 0 is a load to r8 -> stall/bubble for exactly 1 cycle; stall_cnt goes 0 to 1.
- Lane 0 ID is a branch with rt = 9; EXE lane 1 is a load to r9 -> stall 2 consecutive cycles. On the third cycle stall = 0 and fwd_b_id lane 0 = 3'b101, since r9 has moved to WB lane 1 after the two bubbles (MEM forwarding of a load result only when the MEM flags are held as in this scenario).
- MD_LATENCY = 4: md_start_exe pulse, with uses_hilo_id lane 0 held -> stall in the start cycle plus 4 cycles; md_busy high for 4 cycles.
- rst_n deasserted 2 cycles into BUSY -> md_busy = 0 and stall_cnt = 0 immediately. After release, a new md_start_exe gives the full 4-cycle busy period; stall_cnt preset near all-ones saturates and does not wrap.

Source files
------------

// File: rtl/fwd_hazard_unit_n.sv
// N-lane forwarding and hazard unit: EXE/ID forward selects, load-use and branch
// stalls, multiply/divide busy tracking and a saturating stall-cycle counter.
//
// state | meaning
// IDLE  | MD unit free, md_cnt held at 0
// BUSY  | MD op in flight, md_cnt counts down remaining cycles
module fwd_hazard_unit_n #(
   parameter int NUM_LANES  = 2,
   parameter int REG_AW     = 5,
   parameter int LANE_W     = 1,
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_LANES*REG_AW-1:0]       rs_id,
   input  logic [NUM_LANES*REG_AW-1:0]       rt_id,
   input  logic [NUM_LANES-1:0]              branch_id,
   input  logic [NUM_LANES-1:0]              uses_hilo_id,
   input  logic [NUM_LANES*REG_AW-1:0]       rs_exe,
   input  logic [NUM_LANES*REG_AW-1:0]       rt_exe,
   input  logic [NUM_LANES-1:0]              regwrite_exe,
   input  logic [NUM_LANES-1:0]              memread_exe,
   input  logic [NUM_LANES*REG_AW-1:0]       writereg_exe,
   input  logic                              md_start_exe,
   input  logic [NUM_LANES-1:0]              regwrite_mem,
   input  logic [NUM_LANES-1:0]              memread_mem,
   input  logic [NUM_LANES*REG_AW-1:0]       writereg_mem,
   input  logic [NUM_LANES-1:0]              regwrite_wb,
   input  logic [NUM_LANES*REG_AW-1:0]       writereg_wb,
   output logic [NUM_LANES*(2+LANE_W)-1:0]   fwd_a_exe,
   output logic [NUM_LANES*(2+LANE_W)-1:0]   fwd_b_exe,
   output logic [NUM_LANES*(2+LANE_W)-1:0]   fwd_a_id,
   output logic [NUM_LANES*(2+LANE_W)-1:0]   fwd_b_id,
   output logic                              stall_pc,
   output logic                              stall_id,
   output logic                              bubble_exe,
   output logic                              md_busy,
   output logic [CNT_W-1:0]                  stall_cnt
);

   localparam int FW  = 2 + LANE_W;
   localparam int MDW = $clog2(MD_LATENCY + 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

   md_state_t        state_q, state_d;
   logic [MDW-1:0]   md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             stall;
   logic             h_load, h_br_exe, h_br_mem, h_md;

   // WB scanned first so MEM overrides it; ascending lane order lets the youngest lane win.
   function automatic logic [FW-1:0] fwd_sel(
      input logic [REG_AW-1:0]           src,
      input logic [NUM_LANES-1:0]        we_mem,
      input logic [NUM_LANES*REG_AW-1:0] wr_mem,
      input logic [NUM_LANES-1:0]        we_wb,
      input logic [NUM_LANES*REG_AW-1:0] wr_wb
   );
      logic [FW-1:0] sel;
      sel = '0;
      if (src != '0) begin
         for (int j = 0; j < NUM_LANES; j++)
            if (we_wb[j] && wr_wb[j*REG_AW +: REG_AW] == src)
               sel = {LANE_W'(j), 2'b01};
         for (int j = 0; j < NUM_LANES; j++)
            if (we_mem[j] && wr_mem[j*REG_AW +: REG_AW] == src)
               sel = {LANE_W'(j), 2'b10};
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a_exe = '0;
      fwd_b_exe = '0;
      fwd_a_id  = '0;
      fwd_b_id  = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         fwd_a_exe[k*FW +: FW] = fwd_sel(rs_exe[k*REG_AW +: REG_AW], regwrite_mem, writereg_mem,
                                         regwrite_wb, writereg_wb);
         fwd_b_exe[k*FW +: FW] = fwd_sel(rt_exe[k*REG_AW +: REG_AW], regwrite_mem, writereg_mem,
                                         regwrite_wb, writereg_wb);
         fwd_a_id[k*FW +: FW]  = fwd_sel(rs_id[k*REG_AW +: REG_AW], regwrite_mem, writereg_mem,
                                         regwrite_wb, writereg_wb);
         fwd_b_id[k*FW +: FW]  = fwd_sel(rt_id[k*REG_AW +: REG_AW], regwrite_mem, writereg_mem,
                                         regwrite_wb, writereg_wb);
      end
   end

   always_comb begin
      logic [REG_AW-1:0] rs, rt, we, wm;
      h_load   = 1'b0;
      h_br_exe = 1'b0;
      h_br_mem = 1'b0;
      h_md     = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
         rs = rs_id[k*REG_AW +: REG_AW];
         rt = rt_id[k*REG_AW +: REG_AW];
         if (uses_hilo_id[k] && (md_busy || md_start_exe))
            h_md = 1'b1;
         for (int j = 0; j < NUM_LANES; j++) begin
            we = writereg_exe[j*REG_AW +: REG_AW];
            wm = writereg_mem[j*REG_AW +: REG_AW];
            if (regwrite_exe[j] && memread_exe[j] &&
                ((rs != '0 && rs == we) || (rt != '0 && rt == we)))
               h_load = 1'b1;
            if (branch_id[k] && regwrite_exe[j] &&
                ((rs != '0 && rs == we) || (rt != '0 && rt == we)))
               h_br_exe = 1'b1;
            if (branch_id[k] && regwrite_mem[j] && memread_mem[j] &&
                ((rs != '0 && rs == wm) || (rt != '0 && rt == wm)))
               h_br_mem = 1'b1;
         end
      end
   end

   assign stall      = h_load | h_br_exe | h_br_mem | h_md;
   assign stall_pc   = stall;
   assign stall_id   = stall;
   assign bubble_exe = stall;

   // A start while BUSY cannot be a real issue (H_MD holds it back), so it is dropped.
   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      case (state_q)
         IDLE: if (md_start_exe) begin
            state_d  = BUSY;
            md_cnt_d = MDW'(MD_LATENCY - 1);
         end
         BUSY: if (md_cnt_q != '0) md_cnt_d = md_cnt_q - 1'b1;
               else                state_d  = IDLE;
         default: begin
            state_d  = IDLE;
            md_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         md_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign md_busy   = (state_q == BUSY);
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit_n.sv
// Directed bench for fwd_hazard_unit_n with two lanes and a 4-bit stall counter
// so saturation is reachable in a short run.
module tb_fwd_hazard_unit_n;

   localparam int NL = 2;
   localparam int AW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NL*AW-1:0] rs_id, rt_id, rs_exe, rt_exe, writereg_exe, writereg_mem, writereg_wb;
   logic [NL-1:0] branch_id, uses_hilo_id, regwrite_exe, memread_exe;
   logic [NL-1:0] regwrite_mem, memread_mem, regwrite_wb;
   logic          md_start_exe;
   logic [NL*3-1:0] fwd_a_exe, fwd_b_exe, fwd_a_id, fwd_b_id;
   logic          stall_pc, stall_id, bubble_exe, md_busy;
   logic [CW-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit_n #(.NUM_LANES(NL), .REG_AW(AW), .LANE_W(1), .MD_LATENCY(4), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs_id(rs_id), .rt_id(rt_id), .branch_id(branch_id), .uses_hilo_id(uses_hilo_id),
      .rs_exe(rs_exe), .rt_exe(rt_exe), .regwrite_exe(regwrite_exe), .memread_exe(memread_exe),
      .writereg_exe(writereg_exe), .md_start_exe(md_start_exe),
      .regwrite_mem(regwrite_mem), .memread_mem(memread_mem), .writereg_mem(writereg_mem),
      .regwrite_wb(regwrite_wb), .writereg_wb(writereg_wb),
      .fwd_a_exe(fwd_a_exe), .fwd_b_exe(fwd_b_exe), .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id),
      .stall_pc(stall_pc), .stall_id(stall_id), .bubble_exe(bubble_exe),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   task automatic clear_inputs();
      rs_id = '0; rt_id = '0; branch_id = '0; uses_hilo_id = '0;
      rs_exe = '0; rt_exe = '0; regwrite_exe = '0; memread_exe = '0; writereg_exe = '0;
      md_start_exe = 1'b0;
      regwrite_mem = '0; memread_mem = '0; writereg_mem = '0;
      regwrite_wb = '0; writereg_wb = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (md_busy !== 1'b0 || stall_cnt !== '0 || stall_pc !== 1'b0) begin
         failures++;
         $display("FAIL reset: md_busy=%b stall_cnt=%0d stall=%b required 0/0/0", md_busy, stall_cnt, stall_pc);
      end
   endtask

   task automatic test_fwd_exe();
      do_reset();
      rs_exe = {5'd0, 5'd5};
      regwrite_mem = 2'b11; writereg_mem = {5'd5, 5'd5};
      regwrite_wb = 2'b01;  writereg_wb = {5'd0, 5'd5};
      @(negedge clk);
      checks++;
      if (fwd_a_exe[2:0] !== 3'b110 || stall_pc !== 1'b0) begin
         failures++;
         $display("FAIL fwd_mem_youngest: got=%b stall=%b required 110/0", fwd_a_exe[2:0], stall_pc);
      end
      next_cycle();
      regwrite_mem = 2'b00; regwrite_wb = 2'b11; writereg_wb = {5'd5, 5'd5};
      @(negedge clk);
      checks++;
      if (fwd_a_exe[2:0] !== 3'b101) begin
         failures++;
         $display("FAIL fwd_wb_youngest: got=%b required 101", fwd_a_exe[2:0]);
      end
      next_cycle();
      regwrite_wb = 2'b01;
      @(negedge clk);
      checks++;
      if (fwd_a_exe[2:0] !== 3'b001) begin
         failures++;
         $display("FAIL fwd_wb_lane0: got=%b required 001", fwd_a_exe[2:0]);
      end
      next_cycle();
      clear_inputs();
      rt_exe = {5'd0, 5'd3};
      regwrite_exe = 2'b11; writereg_exe = '0;
      regwrite_mem = 2'b11; writereg_mem = '0;
      regwrite_wb = 2'b11;  writereg_wb = '0;
      @(negedge clk);
      checks++;
      if (fwd_b_exe[5:3] !== 3'b000) begin
         failures++;
         $display("FAIL fwd_r0: got=%b required 000", fwd_b_exe[5:3]);
      end
      next_cycle();
      clear_inputs();
      rt_id = {5'd0, 5'd12};
      regwrite_mem = 2'b01; writereg_mem = {5'd0, 5'd12};
      regwrite_wb = 2'b10;  writereg_wb = {5'd12, 5'd0};
      @(negedge clk);
      checks++;
      if (fwd_b_id[2:0] !== 3'b010 || fwd_a_id !== 6'b000000) begin
         failures++;
         $display("FAIL fwd_id_mem: got b=%b a=%b required 010/000000", fwd_b_id[2:0], fwd_a_id);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      rs_id = {5'd8, 5'd0};
      regwrite_exe = 2'b01; memread_exe = 2'b01; writereg_exe = {5'd0, 5'd8};
      @(negedge clk);
      checks++;
      if (stall_pc !== 1'b1 || stall_id !== 1'b1 || bubble_exe !== 1'b1 || stall_cnt !== 4'd0) begin
         failures++;
         $display("FAIL load_use_stall: pc=%b id=%b bub=%b cnt=%0d required 1/1/1/0",
                  stall_pc, stall_id, bubble_exe, stall_cnt);
      end
      next_cycle();
      regwrite_exe = '0; memread_exe = '0; writereg_exe = '0;
      regwrite_mem = 2'b01; memread_mem = 2'b01; writereg_mem = {5'd0, 5'd8};
      @(negedge clk);
      checks++;
      if (stall_pc !== 1'b0 || stall_cnt !== 4'd1 || fwd_a_id[5:3] !== 3'b010) begin
         failures++;
         $display("FAIL load_use_release: stall=%b cnt=%0d fwd=%b required 0/1/010",
                  stall_pc, stall_cnt, fwd_a_id[5:3]);
      end
   endtask

   task automatic test_branch_load();
      do_reset();
      branch_id = 2'b01; rt_id = {5'd0, 5'd9};
      regwrite_exe = 2'b10; memread_exe = 2'b10; writereg_exe = {5'd9, 5'd0};
      @(negedge clk);
      checks++;
      if (stall_pc !== 1'b1) begin
         failures++;
         $display("FAIL br_stall1: got=%b required 1", stall_pc);
      end
      next_cycle();
      regwrite_exe = '0; memread_exe = '0; writereg_exe = '0;
      regwrite_mem = 2'b10; memread_mem = 2'b10; writereg_mem = {5'd9, 5'd0};
      @(negedge clk);
      checks++;
      if (stall_pc !== 1'b1) begin
         failures++;
         $display("FAIL br_stall2: got=%b required 1", stall_pc);
      end
      next_cycle();
      regwrite_mem = '0; memread_mem = '0; writereg_mem = '0;
      regwrite_wb = 2'b10; writereg_wb = {5'd9, 5'd0};
      @(negedge clk);
      checks++;
      if (stall_pc !== 1'b0 || fwd_b_id[2:0] !== 3'b101 || stall_cnt !== 4'd2) begin
         failures++;
         $display("FAIL br_release: stall=%b fwd=%b cnt=%0d required 0/101/2",
                  stall_pc, fwd_b_id[2:0], stall_cnt);
      end
   endtask

   task automatic test_md();
      do_reset();
      md_start_exe = 1'b1; uses_hilo_id = 2'b01;
      @(negedge clk);
      checks++;
      if (stall_pc !== 1'b1 || md_busy !== 1'b0) begin
         failures++;
         $display("FAIL md_start: stall=%b busy=%b required 1/0", stall_pc, md_busy);
      end
      next_cycle();
      md_start_exe = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (md_busy !== 1'b1 || stall_pc !== 1'b1) begin
            failures++;
            $display("FAIL md_busy_cycle%0d: busy=%b stall=%b required 1/1", i, md_busy, stall_pc);
         end
         next_cycle();
      end
      @(negedge clk);
      checks++;
      if (md_busy !== 1'b0 || stall_pc !== 1'b0 || stall_cnt !== 4'd5) begin
         failures++;
         $display("FAIL md_done: busy=%b stall=%b cnt=%0d required 0/0/5", md_busy, stall_pc, stall_cnt);
      end
   endtask

   task automatic test_reset_mid_busy();
      int busy_cycles;
      next_cycle();
      uses_hilo_id = '0;
      md_start_exe = 1'b1;
      next_cycle();
      md_start_exe = 1'b0;
      next_cycle();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (md_busy !== 1'b0 || stall_cnt !== 4'd0) begin
         failures++;
         $display("FAIL reset_mid_busy: busy=%b cnt=%0d required 0/0", md_busy, stall_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      md_start_exe = 1'b1;
      next_cycle();
      md_start_exe = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (md_busy === 1'b1) busy_cycles++;
      end
      checks++;
      if (busy_cycles !== 4) begin
         failures++;
         $display("FAIL md_rerun_len: got=%0d required 4", busy_cycles);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      rs_id = {5'd0, 5'd7};
      regwrite_exe = 2'b01; memread_exe = 2'b01; writereg_exe = {5'd0, 5'd7};
      repeat (14) @(posedge clk);
      @(negedge clk);
      checks++;
      if (stall_cnt !== 4'd14) begin
         failures++;
         $display("FAIL sat_near: got=%0d required 14", stall_cnt);
      end
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks++;
      if (stall_cnt !== 4'd15) begin
         failures++;
         $display("FAIL sat_hold: got=%0d required 15", stall_cnt);
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_fwd_exe();
      test_load_use();
      test_branch_load();
      test_md();
      test_reset_mid_busy();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: run exceeded time limit");
      $fatal(1);
   end

endmodule
